// File: rtl/periferico_raiz_cuadrada_if.sv
// periferico_raiz_cuadrada_if -- simple processor bus for the square-root peripheral.
//
// Signals:
//   entrada_datos [15:0] write data, driven by the master
//   habilitar            bus select; an access happens only while high
//   direccion     [4:0]  byte address; the slave decodes bits [4:2]
//   leer                 read strobe, qualified by habilitar
//   escribir             write strobe, qualified by habilitar
//   salida_datos  [31:0] registered read data, driven by the slave
//
// Modports: master (processor side) and slave (peripheral side).
interface periferico_raiz_cuadrada_if;
    logic [15:0] entrada_datos;
    logic        habilitar;
    logic [4:0]  direccion;
    logic        leer;
    logic        escribir;
    logic [31:0] salida_datos;

    modport master (
        output entrada_datos,
        output habilitar,
        output direccion,
        output leer,
        output escribir,
        input  salida_datos
    );

    modport slave (
        input  entrada_datos,
        input  habilitar,
        input  direccion,
        input  leer,
        input  escribir,
        output salida_datos
    );
endinterface

// File: rtl/periferico_raiz_cuadrada.sv
// periferico_raiz_cuadrada -- memory-mapped 16-bit integer square-root peripheral.
//
// Software writes the radicand to A, writes 1 to INIT, polls DONE and then reads
// RESULT. A sequential restoring core (instancia_raiz) produces one root bit per cycle.
//
// Ports:
//   reloj      clock, all state updates on the rising edge
//   reiniciar  asynchronous active-low reset
//   bus        periferico_raiz_cuadrada_if.slave (data in, strobes, address, read data)
//
// Register map (byte address, index = direccion[4:2]):
//   0x04 A       R/W  radicand [15:0]
//   0x0C INIT    W    bit0 = 1 starts a computation; reads return 0
//   0x10 RESULT  R    root [7:0], remainder [24:16] when built, other bits 0
//   0x14 DONE    R    bit0 = terminado
//   other        writes ignored, reads return 0
//
// Compile-time option:
//   SQRT_REMAINDER_EN  when defined, the final remainder is stored and returned in
//                      RESULT[24:16]; otherwise RESULT[31:8] reads as 0.
module periferico_raiz_cuadrada (
    input  logic                             reloj,
    input  logic                             reiniciar,
    periferico_raiz_cuadrada_if.slave        bus
);

    // ---------------------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------------------
    localparam logic [2:0] IdxA      = 3'd1;
    localparam logic [2:0] IdxInit   = 3'd3;
    localparam logic [2:0] IdxResult = 3'd4;
    localparam logic [2:0] IdxDone   = 3'd5;

    localparam logic [2:0] UltimaIteracion = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } estado_e;

    logic [2:0] indice;
    logic       acceso_escritura;
    logic       acceso_lectura;
    logic       arranque;

    // Byte-lane bits carry no information for 32-bit registers.
    logic       unused_direccion;

    assign indice           = bus.direccion[4:2];
    assign unused_direccion = ^bus.direccion[1:0];
    assign acceso_escritura = bus.habilitar & bus.escribir;
    // A simultaneous write takes priority, so the read data register holds.
    assign acceso_lectura   = bus.habilitar & bus.leer & ~bus.escribir;
    assign arranque         = acceso_escritura & (indice == IdxInit) & bus.entrada_datos[0];

    // ---------------------------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------------------------
    logic [15:0] reg_a_q;
    logic [31:0] salida_q;

    estado_e     estado_q;
    logic [2:0]  iter_q;
    logic [15:0] radicando_q;   // latched copy of A, shifted two bits per iteration
    logic [7:0]  raiz_q;        // partial root, grows one bit per iteration
    logic [8:0]  resto_q;       // partial remainder, never exceeds 2 * partial root
    logic [7:0]  resultado_q;
    logic        terminado_q;
`ifdef SQRT_REMAINDER_EN
    logic [8:0]  resto_final_q;
`endif

    // ---------------------------------------------------------------------------------
    // instancia_raiz: one restoring square-root step
    // ---------------------------------------------------------------------------------
    // Bring down the next two radicand bits and try subtracting 4*root + 1. If it fits,
    // the new root bit is 1 and the difference becomes the remainder.
    logic [10:0] resto_desplazado;
    logic [10:0] prueba;
    logic        cabe;
    logic [10:0] resto_siguiente;
    logic        unused_resto;

    always_comb begin
        resto_desplazado = {resto_q, radicando_q[15:14]};
        prueba           = {1'b0, raiz_q, 2'b01};
        cabe             = (resto_desplazado >= prueba);
        resto_siguiente  = cabe ? (resto_desplazado - prueba) : resto_desplazado;
    end

    // The remainder is bounded by 2 * root, so the top two bits are always zero.
    assign unused_resto = ^resto_siguiente[10:9];

    // ---------------------------------------------------------------------------------
    // Control FSM and core datapath
    // ---------------------------------------------------------------------------------
    always_ff @(posedge reloj or negedge reiniciar) begin
        if (!reiniciar) begin
            estado_q      <= StIdle;
            iter_q        <= '0;
            radicando_q   <= '0;
            raiz_q        <= '0;
            resto_q       <= '0;
            resultado_q   <= '0;
            terminado_q   <= 1'b0;
`ifdef SQRT_REMAINDER_EN
            resto_final_q <= '0;
`endif
        end else begin
            unique case (estado_q)
                StIdle: begin
                    if (arranque) begin
                        radicando_q <= reg_a_q;
                        raiz_q      <= '0;
                        resto_q     <= '0;
                        iter_q      <= '0;
                        terminado_q <= 1'b0;
                        estado_q    <= StCalc;
                    end
                end
                StCalc: begin
                    // Starts written here are not decoded, so they are dropped.
                    radicando_q <= {radicando_q[13:0], 2'b00};
                    raiz_q      <= {raiz_q[6:0], cabe};
                    resto_q     <= resto_siguiente[8:0];
                    iter_q      <= iter_q + 3'd1;
                    if (iter_q == UltimaIteracion) begin
                        estado_q <= StDone;
                    end
                end
                StDone: begin
                    resultado_q   <= raiz_q;
`ifdef SQRT_REMAINDER_EN
                    resto_final_q <= resto_q;
`endif
                    terminado_q   <= 1'b1;
                    estado_q      <= StIdle;
                end
                default: begin
                    estado_q <= StIdle;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------------------
    logic [31:0] valor_resultado;
    logic [31:0] dato_leido;

`ifdef SQRT_REMAINDER_EN
    assign valor_resultado = {7'b0, resto_final_q, 8'b0, resultado_q};
`else
    assign valor_resultado = {24'b0, resultado_q};
`endif

    always_comb begin
        dato_leido = '0;
        case (indice)
            IdxA:      dato_leido = {16'b0, reg_a_q};
            IdxResult: dato_leido = valor_resultado;
            IdxDone:   dato_leido = {31'b0, terminado_q};
            default:   dato_leido = '0;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Bus-visible registers
    // ---------------------------------------------------------------------------------
    always_ff @(posedge reloj or negedge reiniciar) begin
        if (!reiniciar) begin
            reg_a_q  <= '0;
            salida_q <= '0;
        end else begin
            // A may be rewritten during a computation; the core works on its own copy.
            if (acceso_escritura && (indice == IdxA)) begin
                reg_a_q <= bus.entrada_datos;
            end
            if (acceso_lectura) begin
                salida_q <= dato_leido;
            end
        end
    end

    assign bus.salida_datos = salida_q;

endmodule

// File: tb/tb_periferico_raiz_cuadrada.sv
// tb_periferico_raiz_cuadrada -- self-checking bench for periferico_raiz_cuadrada.
// Directed and random radicands are checked against an exhaustive-search reference
// root; cycle-exact completion, reset abort and address decode are checked directly.
module tb_periferico_raiz_cuadrada;

    localparam logic [4:0] DirCero   = 5'h00;
    localparam logic [4:0] DirA      = 5'h04;
    localparam logic [4:0] DirInit   = 5'h0C;
    localparam logic [4:0] DirResult = 5'h10;
    localparam logic [4:0] DirDone   = 5'h14;
    localparam logic [4:0] DirLibre  = 5'h1C;

    logic reloj = 1'b0;
    logic reiniciar;

    periferico_raiz_cuadrada_if bus ();

    periferico_raiz_cuadrada dut (
        .reloj     (reloj),
        .reiniciar (reiniciar),
        .bus       (bus)
    );

    always #5 reloj = ~reloj;

    int unsigned ciclo = 0;
    always @(posedge reloj) ciclo <= ciclo + 1;

    int          vectores = 0;
    int          fallos   = 0;
    logic [31:0] ultimo_res = '0;

    // Reference: largest r with r*r <= a, found by plain search.
    function automatic logic [31:0] modelo(input logic [15:0] a);
        int unsigned r = 0;
        logic [31:0] res;
        for (int unsigned k = 0; k < 256; k++) begin
            if (k * k <= 32'(a)) r = k;
        end
        res = r;
`ifdef SQRT_REMAINDER_EN
        res = res | ((32'(a) - r * r) << 16);
`endif
        return res;
    endfunction

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vectores++;
        assert (obs === esp) else begin
            fallos++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    // Each bus task consumes exactly one rising edge when entered just after an edge.
    task automatic escribir_reg(input logic [4:0] dir, input logic [15:0] dato);
        @(negedge reloj);
        bus.habilitar     = 1'b1;
        bus.escribir      = 1'b1;
        bus.leer          = 1'b0;
        bus.direccion     = dir;
        bus.entrada_datos = dato;
        @(posedge reloj);
        #1;
        bus.habilitar = 1'b0;
        bus.escribir  = 1'b0;
    endtask

    task automatic leer_reg(input logic [4:0] dir, output logic [31:0] dato);
        @(negedge reloj);
        bus.habilitar = 1'b1;
        bus.escribir  = 1'b0;
        bus.leer      = 1'b1;
        bus.direccion = dir;
        @(posedge reloj);
        #1;
        dato          = bus.salida_datos;
        bus.habilitar = 1'b0;
        bus.leer      = 1'b0;
    endtask

    task automatic esperar_ciclo(input int unsigned objetivo);
        int guardia = 0;
        while (ciclo < objetivo && guardia < 200) begin
            @(posedge reloj);
            #1;
            guardia++;
        end
        comprobar("cycle_alignment", ciclo, objetivo);
    endtask

    task automatic ejecutar(input logic [15:0] a, input string tag);
        logic [31:0] d = '0;
        bit          listo = 1'b0;
        escribir_reg(DirA, a);
        escribir_reg(DirInit, 16'h0001);
        for (int i = 0; i < 30 && !listo; i++) begin
            leer_reg(DirDone, d);
            if (d == 32'd1) listo = 1'b1;
        end
        comprobar({tag, "_done"}, d, 32'd1);
        leer_reg(DirResult, d);
        ultimo_res = modelo(a);
        comprobar({tag, "_result"}, d, ultimo_res);
    endtask

    initial begin
        logic [31:0] d;
        int unsigned e0;
        logic [15:0] a_rand;

        reiniciar         = 1'b0;
        bus.habilitar     = 1'b0;
        bus.leer          = 1'b0;
        bus.escribir      = 1'b0;
        bus.direccion     = '0;
        bus.entrada_datos = '0;
        #1;
        comprobar("reset_salida", bus.salida_datos, 32'd0);
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        reiniciar = 1'b1;
        @(posedge reloj);
        #1;

        leer_reg(DirA, d);      comprobar("reset_a", d, 32'd0);
        leer_reg(DirResult, d); comprobar("reset_result", d, 32'd0);
        leer_reg(DirDone, d);   comprobar("reset_done", d, 32'd0);

        // Directed radicands
        ejecutar(16'h0271, "a625");
        ejecutar(16'hFFFF, "affff");
        ejecutar(16'h0000, "a0");
        ejecutar(16'd26,   "a26");
        ejecutar(16'h0001, "a1");

        // Random radicands
        for (int i = 0; i < 15; i++) begin
            a_rand = 16'($urandom_range(0, 65535));
            ejecutar(a_rand, "rand");
            leer_reg(DirA, d);
            comprobar("rand_a_readback", d, {16'b0, a_rand});
        end

        // Unmapped and write-only addresses read as zero
        escribir_reg(DirA, 16'hBEEF);
        leer_reg(DirA, d);      comprobar("a_beef", d, 32'h0000BEEF);
        leer_reg(DirInit, d);   comprobar("read_init", d, 32'd0);
        leer_reg(DirA, d);      comprobar("a_beef_2", d, 32'h0000BEEF);
        leer_reg(DirCero, d);   comprobar("read_00", d, 32'd0);
        leer_reg(DirA, d);      comprobar("a_beef_3", d, 32'h0000BEEF);
        leer_reg(DirLibre, d);  comprobar("read_1c", d, 32'd0);
        escribir_reg(DirLibre, 16'h5555);
        leer_reg(DirA, d);      comprobar("a_after_1c", d, 32'h0000BEEF);
        leer_reg(DirResult, d); comprobar("result_after_1c", d, ultimo_res);
        leer_reg(DirDone, d);   comprobar("done_after_1c", d, 32'd1);

        // Both strobes: write wins, read data holds
        leer_reg(DirA, d);
        @(negedge reloj);
        bus.habilitar     = 1'b1;
        bus.leer          = 1'b1;
        bus.escribir      = 1'b1;
        bus.direccion     = DirA;
        bus.entrada_datos = 16'h0042;
        @(posedge reloj);
        #1;
        bus.habilitar = 1'b0;
        bus.leer      = 1'b0;
        bus.escribir  = 1'b0;
        comprobar("both_strobes_hold", bus.salida_datos, 32'h0000BEEF);
        leer_reg(DirA, d);      comprobar("both_strobes_write", d, 32'h00000042);

        // Exact completion timing, A rewrite and ignored start during the computation
        escribir_reg(DirA, 16'd1000);
        escribir_reg(DirInit, 16'h0001);
        e0 = ciclo;
        escribir_reg(DirA, 16'd9);                                      // E0+1
        leer_reg(DirResult, d);  comprobar("result_during_calc", d, ultimo_res); // E0+2
        escribir_reg(DirInit, 16'h0001);                                // E0+3
        esperar_ciclo(e0 + 4);
        leer_reg(DirDone, d);    comprobar("done_at_e0p5", d, 32'd0);   // E0+5
        esperar_ciclo(e0 + 8);
        leer_reg(DirDone, d);    comprobar("done_at_e0p9", d, 32'd0);   // E0+9
        leer_reg(DirDone, d);    comprobar("done_at_e0p10", d, 32'd1);  // E0+10
        ultimo_res = modelo(16'd1000);
        leer_reg(DirResult, d);  comprobar("result_latched_a", d, ultimo_res);
        leer_reg(DirA, d);       comprobar("a_rewritten", d, 32'd9);

        // Reset in the middle of a computation
        escribir_reg(DirA, 16'd50000);
        leer_reg(DirResult, d);
        escribir_reg(DirInit, 16'h0001);
        e0 = ciclo;
        esperar_ciclo(e0 + 4);
        reiniciar = 1'b0;
        #1;
        comprobar("abort_salida", bus.salida_datos, 32'd0);
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        reiniciar = 1'b1;
        @(posedge reloj);
        #1;
        leer_reg(DirDone, d);    comprobar("abort_done", d, 32'd0);
        leer_reg(DirResult, d);  comprobar("abort_result", d, 32'd0);
        leer_reg(DirA, d);       comprobar("abort_a", d, 32'd0);
        ejecutar(16'h0271, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
